// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bit_serializer
// Function : Parallel-to-serial converter, MSB first, with a one-word hold
//            register so back-to-back words stream without idle gaps.
// Revision : 1.0 - initial release
// ============================================================================
module bit_serializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         seq,
  output logic         seq_valid,
  output logic         busy
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;
  logic [W-1:0]  hold;
  logic          hold_full;
  logic          accept;
  logic          last_bit;

  // Handshake: a word moves only when valid meets ready on the same edge.
  assign accept   = din_valid && din_ready;
  assign last_bit = (cnt == CNT_ZERO);

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; clr overrides every functional transition.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) state_nxt = S_SHIFT;
        end
        S_SHIFT: begin
          // Leave SHIFT only when the last bit goes out with nothing queued.
          if (last_bit && !hold_full && !accept) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: shift register, bit counter and the one-word hold buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr        <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (clr) begin
      sr        <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            sr  <= din;
            cnt <= CNT_MAX;
          end
        end
        S_SHIFT: begin
          if (!last_bit) begin
            sr  <= {sr[W-2:0], 1'b0};
            cnt <= cnt - CW'(1);
            // din_ready is low while hold is full, so hold is never clobbered.
            if (accept) begin
              hold      <= din;
              hold_full <= 1'b1;
            end
          end else if (hold_full) begin
            sr        <= hold;
            cnt       <= CNT_MAX;
            hold_full <= 1'b0;
          end else if (accept) begin
            sr  <= din;
            cnt <= CNT_MAX;
          end else begin
            sr <= '0;
          end
        end
        default: begin
          sr <= '0;
        end
      endcase
    end
  end

  // Outputs derived from registered state (and clr for the ready handshake).
  always_comb begin
    seq       = 1'b0;
    seq_valid = 1'b0;
    if (state == S_SHIFT) begin
      seq       = sr[W-1];
      seq_valid = 1'b1;
    end
    busy      = (state == S_SHIFT) || hold_full;
    din_ready = !hold_full && !clr;
  end

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serializer
// Function : Directed, table-driven self-checking bench for bit_serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk;
  logic         clk_en;
  logic         rst;
  logic         clr;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         seq;
  logic         seq_valid;
  logic         busy;

  int n_cmp;
  int n_bad;
  int det_hits;
  logic [3:0] det_hist;
  int det_bits;

  typedef struct {
    logic         vld;
    logic [W-1:0] d;
    logic         cl;
    logic         e_seq;
    logic         e_sv;
    logic         e_busy;
    logic         e_rdy;
  } vec_t;

  vec_t tbl[$];
  int seg_a, seg_a_end, seg_b, seg_b_end, seg_c, seg_c_end, seg_d, seg_d_end;

  bit_serializer #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .seq       (seq),
    .seq_valid (seq_valid),
    .busy      (busy)
  );

  // Gated clock so the reset state can be observed with clk stopped.
  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic [W-1:0] d, input logic cl,
                              input logic es, input logic ev, input logic eb, input logic er);
    vec_t v;
    v.vld = vld; v.d = d; v.cl = cl;
    v.e_seq = es; v.e_sv = ev; v.e_busy = eb; v.e_rdy = er;
    return v;
  endfunction

  function automatic vec_t idle_row(input logic vld, input logic [W-1:0] d);
    return mk(vld, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  // Each row: drive inputs, check outputs for the current cycle, then clock.
  // Called at 1 time unit after a rising edge.
  task automatic run_rows(input string tag, input int first, input int last);
    det_hist = '0;
    det_bits = 0;
    det_hits = 0;
    for (int i = first; i <= last; i++) begin
      din_valid = tbl[i].vld;
      din       = tbl[i].d;
      clr       = tbl[i].cl;
      #1;
      chk($sformatf("%s[%0d].seq", tag, i - first), {31'd0, seq}, {31'd0, tbl[i].e_seq});
      chk($sformatf("%s[%0d].seq_valid", tag, i - first), {31'd0, seq_valid}, {31'd0, tbl[i].e_sv});
      chk($sformatf("%s[%0d].busy", tag, i - first), {31'd0, busy}, {31'd0, tbl[i].e_busy});
      chk($sformatf("%s[%0d].din_ready", tag, i - first), {31'd0, din_ready}, {31'd0, tbl[i].e_rdy});
      if (seq_valid) begin
        det_hist = {det_hist[2:0], seq};
        det_bits++;
        if (det_bits >= 4 && det_hist == 4'b1101) det_hits++;
      end
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    din       = '0;
    clr       = 1'b0;
  endtask

  task automatic fill_table();
    logic [W-1:0] w;
    logic [W-1:0] w2;
    // Single word D0 into an idle block.
    seg_a = tbl.size();
    w = 8'hD0;
    tbl.push_back(idle_row(1'b1, w));
    for (int i = W - 1; i >= 0; i--) tbl.push_back(mk(1'b0, '0, 1'b0, w[i], 1'b1, 1'b1, 1'b1));
    tbl.push_back(idle_row(1'b0, '0));
    seg_a_end = tbl.size() - 1;
    // D0 then DD one cycle later: DD waits in hold, no gap between words.
    seg_b = tbl.size();
    w  = 8'hD0;
    w2 = 8'hDD;
    tbl.push_back(idle_row(1'b1, w));
    tbl.push_back(mk(1'b1, w2, 1'b0, w[W-1], 1'b1, 1'b1, 1'b1));
    for (int i = W - 2; i >= 0; i--) tbl.push_back(mk(1'b0, '0, 1'b0, w[i], 1'b1, 1'b1, 1'b0));
    for (int i = W - 1; i >= 0; i--) tbl.push_back(mk(1'b0, '0, 1'b0, w2[i], 1'b1, 1'b1, 1'b1));
    tbl.push_back(idle_row(1'b0, '0));
    seg_b_end = tbl.size() - 1;
    // A5, next word 3C offered only during A5's last bit: direct load, no gap.
    seg_c = tbl.size();
    w  = 8'hA5;
    w2 = 8'h3C;
    tbl.push_back(idle_row(1'b1, w));
    for (int i = W - 1; i >= 1; i--) tbl.push_back(mk(1'b0, '0, 1'b0, w[i], 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, w2, 1'b0, w[0], 1'b1, 1'b1, 1'b1));
    for (int i = W - 1; i >= 0; i--) tbl.push_back(mk(1'b0, '0, 1'b0, w2[i], 1'b1, 1'b1, 1'b1));
    tbl.push_back(idle_row(1'b0, '0));
    seg_c_end = tbl.size() - 1;
    // FF shifting with 0F held; clr during bit 3 flushes both.
    seg_d = tbl.size();
    tbl.push_back(idle_row(1'b1, 8'hFF));
    tbl.push_back(mk(1'b1, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    for (int i = 0; i < 10; i++) tbl.push_back(idle_row(1'b0, '0));
    seg_d_end = tbl.size() - 1;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    det_hits  = 0;
    det_hist  = '0;
    det_bits  = 0;
    clk       = 1'b0;
    clk_en    = 1'b0;
    rst       = 1'b0;
    clr       = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    fill_table();

    // Reset with the clock stopped: outputs must already be at reset values.
    #3;
    chk("rst_noclk.seq", {31'd0, seq}, 32'd0);
    chk("rst_noclk.seq_valid", {31'd0, seq_valid}, 32'd0);
    chk("rst_noclk.busy", {31'd0, busy}, 32'd0);
    chk("rst_noclk.din_ready", {31'd0, din_ready}, 32'd1);

    clk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;

    run_rows("single_d0", seg_a, seg_a_end);
    run_rows("b2b_d0_dd", seg_b, seg_b_end);
    chk("b2b_detector_1101_hits", det_hits, 32'd3);
    run_rows("lastbit_a5_3c", seg_c, seg_c_end);
    run_rows("clr_ff_0f", seg_d, seg_d_end);

    // Mid-word asynchronous reset with a word held pending.
    din_valid = 1'b1;
    din       = 8'hD0;
    @(posedge clk);
    #1;
    din       = 8'h0F;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din       = '0;
    @(posedge clk);
    #1;
    chk("midrst_pre.seq_valid", {31'd0, seq_valid}, 32'd1);
    chk("midrst_pre.busy", {31'd0, busy}, 32'd1);
    chk("midrst_pre.din_ready", {31'd0, din_ready}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_async.seq", {31'd0, seq}, 32'd0);
    chk("midrst_async.seq_valid", {31'd0, seq_valid}, 32'd0);
    chk("midrst_async.busy", {31'd0, busy}, 32'd0);
    chk("midrst_async.din_ready", {31'd0, din_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("midrst_held.seq_valid", {31'd0, seq_valid}, 32'd0);
    chk("midrst_held.busy", {31'd0, busy}, 32'd0);
    #2;
    rst = 1'b1;
    run_rows("after_rst_d0", seg_a, seg_a_end);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
